// File: rtl/aclk_controller_if.sv
// Bundles the alarm-clock controller's keypad/button inputs and its
// display-select and strobe outputs.
interface aclk_controller_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic       reset_count;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
  );
endinterface

// File: rtl/aclk_controller.sv
// Alarm-clock main control FSM: decodes keypad/buttons into display selects and
// load/shift strobes, abandoning key entry after TIMEOUT idle one-second ticks.
module aclk_controller #(
  parameter logic [3:0] NOKEY   = 4'd10,
  parameter int         TIMEOUT = 10,
  parameter int         CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  aclk_controller_if.slave bus
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout;
  logic             key_pressed;

  assign waiting     = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign timeout     = bus.one_second && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign key_pressed = (bus.key != NOKEY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts at the timeout tick so it can never wrap past TIMEOUT.
  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      if (timeout) begin
        cnt_d = '0;
      end else if (bus.one_second) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button)  state_d = SHOW_ALARM;
        else if (key_pressed)  state_d = KEY_STORED;
      end
      KEY_STORED:       state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed)      state_d = KEY_ENTRY;
        else if (timeout)      state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button)     state_d = SET_ALARM_TIME;
        else if (bus.time_button) state_d = SET_CURRENT_TIME;
        else if (key_pressed)     state_d = KEY_STORED;
        else if (timeout)         state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // Moore outputs: decoded from the registered state only.
  always_comb begin
    bus.shift         = 1'b0;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    bus.reset_count   = 1'b0;
    case (state_q)
      KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
      end
      KEY_WAITED:       bus.show_new_time = 1'b1;
      KEY_ENTRY:        bus.show_new_time = 1'b1;
      SHOW_ALARM:       bus.show_a        = 1'b1;
      SET_ALARM_TIME:   bus.load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        bus.load_new_c  = 1'b1;
        bus.reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aclk_controller.md
Name: aclk_controller

Overview:
- Main control FSM of the alarm clock, upstream of the LCD display stage.
- Decodes keypad and button activity and generates the display selects `show_new_time` and `show_a` consumed by the display stage.
- Also generates the load strobes for the alarm register and time counter, and the shift strobe for the key buffer.
- Key-entry mode is abandoned automatically after a timeout measured in one-second ticks.

Parameters:
- NOKEY, 4'd10, key code meaning "no key pressed"; any other value is a digit press.
- TIMEOUT, 10, number of `one_second` ticks without a key press before key entry is abandoned.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- one_second  input  1  single-cycle tick, once per second, synchronous to clock.
- key  input  4  debounced keypad code; NOKEY when idle.
- alarm_button  input  1  level, high while the alarm button is held.
- time_button  input  1  level, high while the time button is held.
- shift  output  1  pulse: shift `key` into the key buffer.
- show_new_time  output  1  display shows the key buffer.
- show_a  output  1  display shows the alarm time.
- load_new_a  output  1  pulse: alarm register loads the key buffer.
- load_new_c  output  1  pulse: time counter loads the key buffer.
- reset_count  output  1  pulse: clear the seconds prescaler, concurrent with load_new_c.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- On reset the state goes to SHOW_TIME, the timeout counter goes to 0, and all outputs are 0.
- All outputs are Moore: registered state, outputs decoded from state only.
- States, their outputs, and transitions in priority order (default is to stay):
  - SHOW_TIME: all outputs 0.
    - alarm_button -> SHOW_ALARM.
    - key != NOKEY -> KEY_STORED.
  - KEY_STORED: shift=1, show_new_time=1.
    - Unconditionally -> KEY_WAITED (exactly one shift per press).
  - KEY_WAITED: show_new_time=1.
    - key == NOKEY -> KEY_ENTRY.
    - timeout -> SHOW_TIME.
  - KEY_ENTRY: show_new_time=1.
    - alarm_button -> SET_ALARM_TIME.
    - time_button -> SET_CURRENT_TIME.
    - key != NOKEY -> KEY_STORED.
    - timeout -> SHOW_TIME.
  - SHOW_ALARM: show_a=1.
    - !alarm_button -> SHOW_TIME.
  - SET_ALARM_TIME: load_new_a=1.
    - Unconditionally -> SHOW_TIME.
  - SET_CURRENT_TIME: load_new_c=1, reset_count=1.
    - Unconditionally -> SHOW_TIME.
- Timeout counter:
  - Counts `one_second` ticks only while in KEY_WAITED or KEY_ENTRY.
  - Cleared to 0 in every other state; therefore cleared on each new key (KEY_STORED).
  - timeout = one_second && count == TIMEOUT-1.
  - The counter never wraps: it is cleared on the timeout transition.
- Simultaneous events resolve by the priority order above:
  - alarm_button and time_button together in KEY_ENTRY -> SET_ALARM_TIME.
  - key press and timeout in the same cycle in KEY_ENTRY -> KEY_STORED; the press wins and the counter clears.
- A key held across many cycles produces exactly one shift; no repeat until key returns to NOKEY.
- In SHOW_TIME, alarm_button takes priority over a simultaneous key press.
- Buttons held on exit from SET_*:
  - Next cycle is SHOW_TIME.
  - A still-held alarm_button then enters SHOW_ALARM; this is accepted behaviour.
- Reset asserted mid-sequence (any state, any count):
  - SHOW_TIME and count 0 immediately, no clock needed.
  - No load strobe may be emitted on reset release.
- Strobes shift, load_new_a, load_new_c and reset_count are exactly 1 clock wide.
- show_new_time and show_a are never high together.

Test Plan:
1. Reset sequence:
   - Assert reset mid-KEY_ENTRY with count=5, release.
   - Required: all outputs 0 asynchronously; state SHOW_TIME; next key press gives a full TIMEOUT window.
2. Digit entry then alarm set:
   - key=3 held 5 cycles, then NOKEY, then alarm_button for 1 cycle.
   - Required: one shift pulse; show_new_time high from KEY_STORED onward; then one load_new_a pulse; then SHOW_TIME.
3. Time set:
   - key=7 press/release, then time_button.
   - Required: load_new_c and reset_count high in the same single cycle; then return to SHOW_TIME.
4. Timeout:
   - key=1 press/release, then 10 one_second ticks with no key.
   - Required: show_new_time drops on the cycle after the 10th tick; no load pulses.
   - Variant: a key press at tick 9 restarts the count.
5. Show alarm:
   - alarm_button held 20 cycles from SHOW_TIME.
   - Required: show_a=1 for the full hold, 0 one cycle after release; show_new_time stays 0.
6. Priority:
   - In KEY_ENTRY drive alarm_button and time_button in the same cycle -> only load_new_a pulses.
   - Key press coincident with the 10th tick -> KEY_STORED, not SHOW_TIME.
